queue_bank: RTL and testbench

- Parametrised successor to the single INBOX/OUTBOX FIFO pair. Holds NQ independent queues of DW-bit entries, each 2**LGFLEN deep.
- One command port executes PUSH, POP, MOVE (atomic pop-from-source, push-to-destination, generalising inbox→outbox transfer) or CLEAR.
- A synchronous dump port lets the VGA text overlay display any entry of any queue.
- Sits between rxuartlite/txuartlite and the display ramMux, replacing the separate ufifo instances.

---
 rtl/queue_bank_pkg.sv | 15 +
 rtl/qb_queue_ctrl.sv | 60 ++++++
 rtl/queue_bank.sv | 180 ++++++++++++++++++
 tb/tb_queue_bank.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_bank_pkg.sv
// queue_bank shared definitions.
// Opcodes are shared with the UART command decoder.
package queue_bank_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_MOVE  = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;

  function automatic int cnt_w(int lgflen);
    return lgflen + 1;
  endfunction

endpackage

// File: rtl/qb_queue_ctrl.sv
// Pointer, occupancy and flag state for one queue.
// Simultaneous push+pop is a rotate: count is unchanged.
module qb_queue_ctrl
  import queue_bank_pkg::*;
#(
  parameter int LGFLEN = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clr,
  input  logic                      push,
  input  logic                      pop,
  output logic [LGFLEN-1:0]         rd_ptr,
  output logic [LGFLEN-1:0]         wr_ptr,
  output logic [cnt_w(LGFLEN)-1:0]  cnt,
  output logic                      empty_n,
  output logic                      full
);

  localparam int CW = cnt_w(LGFLEN);
  localparam logic [CW-1:0] DEPTH = CW'(2**LGFLEN);
  localparam logic [CW-1:0] C1 = CW'(1);
  localparam logic [LGFLEN-1:0] P1 = LGFLEN'(1);

  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (push && !pop)
      cnt_nxt = cnt + C1;
    else if (pop && !push)
      cnt_nxt = cnt - C1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      empty_n <= 1'b0;
      full    <= 1'b0;
    end else begin
      if (clr) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop)
          rd_ptr <= rd_ptr + P1;
        if (push)
          wr_ptr <= wr_ptr + P1;
      end
      cnt     <= cnt_nxt;
      empty_n <= (cnt_nxt != '0);
      full    <= (cnt_nxt == DEPTH);
    end
  end

endmodule

// File: rtl/queue_bank.sv
// NQ independent FIFOs sharing one storage array, driven by a
// single command port, with a registered dump port for display.
module queue_bank
  import queue_bank_pkg::*;
#(
  parameter  int NQ     = 4,
  parameter  int DW     = 8,
  parameter  int LGFLEN = 5,
  localparam int QW     = $clog2(NQ)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  input  logic [2:0]                 cmd_op,
  input  logic [QW-1:0]              cmd_q,
  input  logic [QW-1:0]              cmd_dst,
  input  logic [DW-1:0]              cmd_data,
  output logic                       rsp_valid,
  output logic                       rsp_err,
  output logic [DW-1:0]              rsp_data,
  output logic [NQ-1:0]              empty_n,
  output logic [NQ-1:0]              full,
  output logic [NQ*(LGFLEN+1)-1:0]   count,
  input  logic [QW-1:0]              dmp_q,
  input  logic [LGFLEN-1:0]          dmp_pos,
  output logic [DW-1:0]              dmp_data,
  output logic                       dmp_valid
);

  localparam int CW = cnt_w(LGFLEN);
  localparam int D  = 2**LGFLEN;
  localparam int AW = QW + LGFLEN;
  localparam logic [CW-1:0] DEPTH = CW'(D);

  logic [DW-1:0]     mem [NQ*D];

  logic [LGFLEN-1:0] rd_ptr [NQ];
  logic [LGFLEN-1:0] wr_ptr [NQ];
  logic [CW-1:0]     cnt    [NQ];
  logic [NQ-1:0]     q_push;
  logic [NQ-1:0]     q_pop;
  logic [NQ-1:0]     q_clr;

  logic              q_ok;
  logic              d_ok;
  logic [QW-1:0]     sq;
  logic [QW-1:0]     sd;
  logic [QW-1:0]     wq;
  logic              s_empty;
  logic              s_full;
  logic              d_full;
  logic              is_nop;
  logic              is_push;
  logic              is_pop;
  logic              is_move;
  logic              is_clr;
  logic              err;
  logic              rd;
  logic              wr;
  logic              clr_en;
  logic [DW-1:0]     rdata;
  logic [DW-1:0]     wdata;
  logic [AW-1:0]     waddr;

  logic              dq_ok;
  logic [QW-1:0]     dsel;
  logic              dvalid;
  logic [AW-1:0]     daddr;

  for (genvar gi = 0; gi < NQ; gi++) begin : g_q
    assign q_push[gi] = wr && (wq == QW'(gi));
    assign q_pop[gi]  = rd && (sq == QW'(gi));
    assign q_clr[gi]  = clr_en && (sq == QW'(gi));
    assign count[gi*CW +: CW] = cnt[gi];

    qb_queue_ctrl #(
      .LGFLEN (LGFLEN)
    ) u_ctrl (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (q_clr[gi]),
      .push    (q_push[gi]),
      .pop     (q_pop[gi]),
      .rd_ptr  (rd_ptr[gi]),
      .wr_ptr  (wr_ptr[gi]),
      .cnt     (cnt[gi]),
      .empty_n (empty_n[gi]),
      .full    (full[gi])
    );
  end

  // Out-of-range queue ids are folded to 0 so indexing stays legal.
  assign q_ok    = int'(cmd_q) < NQ;
  assign d_ok    = int'(cmd_dst) < NQ;
  assign sq      = q_ok ? cmd_q : '0;
  assign sd      = d_ok ? cmd_dst : '0;
  assign s_empty = (cnt[sq] == '0);
  assign s_full  = (cnt[sq] == DEPTH);
  assign d_full  = (cnt[sd] == DEPTH);
  assign rdata   = mem[{sq, rd_ptr[sq]}];
  assign waddr   = {wq, wr_ptr[wq]};

  assign is_nop  = cmd_valid && (cmd_op == OP_NOP);
  assign is_push = cmd_valid && (cmd_op == OP_PUSH);
  assign is_pop  = cmd_valid && (cmd_op == OP_POP);
  assign is_move = cmd_valid && (cmd_op == OP_MOVE);
  assign is_clr  = cmd_valid && (cmd_op == OP_CLEAR);

  always_comb begin
    err    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    clr_en = 1'b0;
    wq     = sq;
    wdata  = cmd_data;
    unique case (1'b1)
      is_nop: ;
      is_push:
        if (!q_ok || s_full)
          err = 1'b1;
        else
          wr = 1'b1;
      is_pop:
        if (!q_ok || s_empty)
          err = 1'b1;
        else
          rd = 1'b1;
      // Self-move rotates, so a full destination is fine there.
      is_move:
        if (!q_ok || !d_ok || s_empty || (sq != sd && d_full))
          err = 1'b1;
        else begin
          rd    = 1'b1;
          wr    = 1'b1;
          wq    = sd;
          wdata = rdata;
        end
      is_clr:
        if (!q_ok)
          err = 1'b1;
        else
          clr_en = 1'b1;
      default:
        err = cmd_valid;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= cmd_valid;
      rsp_err   <= err;
      rsp_data  <= rd ? rdata : '0;
    end
  end

  assign dq_ok  = int'(dmp_q) < NQ;
  assign dsel   = dq_ok ? dmp_q : '0;
  assign dvalid = dq_ok && ({1'b0, dmp_pos} < cnt[dsel]);
  assign daddr  = {dsel, rd_ptr[dsel] + dmp_pos};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmp_valid <= 1'b0;
      dmp_data  <= '0;
    end else begin
      dmp_valid <= dvalid;
      dmp_data  <= dvalid ? mem[daddr] : '0;
    end
  end

endmodule

// File: tb/tb_queue_bank.sv
// Self-checking bench for queue_bank: vector table, directed
// corner sequences and random traffic against a queue model.
module tb_queue_bank;
  import queue_bank_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_q;
  logic [1:0]  cmd_dst;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic        rsp_err;
  logic [7:0]  rsp_data;
  logic [3:0]  empty_n;
  logic [3:0]  full;
  logic [23:0] count;
  logic [1:0]  dmp_q;
  logic [4:0]  dmp_pos;
  logic [7:0]  dmp_data;
  logic        dmp_valid;

  int n_pass;
  int n_tot;

  logic [7:0] mq [4][$];

  queue_bank dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_q     (cmd_q),
    .cmd_dst   (cmd_dst),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .empty_n   (empty_n),
    .full      (full),
    .count     (count),
    .dmp_q     (dmp_q),
    .dmp_pos   (dmp_pos),
    .dmp_data  (dmp_data),
    .dmp_valid (dmp_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    int         q;
    int         dst;
    logic [7:0] d;
    bit         err;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl [7];

  function automatic int cnt_of(int i);
    return int'(count[i*6 +: 6]);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic model(input logic [2:0] op, input int q, input int dst,
                       input logic [7:0] d, output bit e, output logic [7:0] r);
    logic [7:0] v;
    e = 0;
    r = 8'h00;
    case (op)
      OP_NOP: ;
      OP_PUSH:
        if (mq[q].size() == 32) e = 1;
        else mq[q].push_back(d);
      OP_POP:
        if (mq[q].size() == 0) e = 1;
        else r = mq[q].pop_front();
      OP_MOVE:
        if (mq[q].size() == 0) e = 1;
        else if (q != dst && mq[dst].size() == 32) e = 1;
        else begin
          v = mq[q].pop_front();
          mq[dst].push_back(v);
          r = v;
        end
      OP_CLEAR: mq[q].delete();
      default: e = 1;
    endcase
  endtask

  task automatic run(input logic [2:0] op, input int q, input int dst,
                     input logic [7:0] d, input int dq, input int dp);
    bit         ee;
    logic [7:0] ed;
    int         edv;
    int         edd;
    edv = (dp < mq[dq].size()) ? 1 : 0;
    edd = edv ? int'(mq[dq][dp]) : 0;
    model(op, q, dst, d, ee, ed);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_q     = 2'(q);
    cmd_dst   = 2'(dst);
    cmd_data  = d;
    dmp_q     = 2'(dq);
    dmp_pos   = 5'(dp);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("rsp_valid", int'(rsp_valid), 1);
    chk("rsp_err", int'(rsp_err), int'(ee));
    chk("rsp_data", int'(rsp_data), int'(ed));
    chk("dmp_valid", int'(dmp_valid), edv);
    chk("dmp_data", int'(dmp_data), edd);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("count%0d", i), cnt_of(i), mq[i].size());
      chk($sformatf("empty_n%0d", i), int'(empty_n[i]), (mq[i].size() != 0) ? 1 : 0);
      chk($sformatf("full%0d", i), int'(full[i]), (mq[i].size() == 32) ? 1 : 0);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++)
      run(OP_CLEAR, i, 0, 8'h00, 0, 0);
  endtask

  initial begin
    int r;
    int op_i;
    n_pass    = 0;
    n_tot     = 0;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_q     = '0;
    cmd_dst   = '0;
    cmd_data  = '0;
    dmp_q     = '0;
    dmp_pos   = '0;

    tbl[0] = '{OP_PUSH, 0, 0, 8'h41, 1'b0, 8'h00};
    tbl[1] = '{OP_PUSH, 0, 0, 8'h42, 1'b0, 8'h00};
    tbl[2] = '{OP_PUSH, 0, 0, 8'h43, 1'b0, 8'h00};
    tbl[3] = '{OP_POP,  0, 0, 8'h00, 1'b0, 8'h41};
    tbl[4] = '{OP_POP,  0, 0, 8'h00, 1'b0, 8'h42};
    tbl[5] = '{OP_POP,  0, 0, 8'h00, 1'b0, 8'h43};
    tbl[6] = '{OP_POP,  0, 0, 8'h00, 1'b1, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    chk("reset rsp_valid", int'(rsp_valid), 0);
    chk("reset rsp_err", int'(rsp_err), 0);
    chk("reset count", int'(count), 0);
    chk("reset empty_n", int'(empty_n), 0);
    chk("reset full", int'(full), 0);
    chk("reset dmp_valid", int'(dmp_valid), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle rsp_valid", int'(rsp_valid), 0);

    for (int i = 0; i < 7; i++) begin
      run(tbl[i].op, tbl[i].q, tbl[i].dst, tbl[i].d, 0, 0);
      chk($sformatf("tbl%0d err", i), int'(rsp_err), int'(tbl[i].err));
      chk($sformatf("tbl%0d data", i), int'(rsp_data), int'(tbl[i].dat));
    end
    chk("q0 drained", int'(empty_n[0]), 0);

    // Fill/overflow/drain, then again with pointers offset by 7.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1)
        for (int i = 0; i < 7; i++) begin
          run(OP_PUSH, 1, 0, 8'hEE, 1, 0);
          run(OP_POP, 1, 0, 8'h00, 1, 0);
        end
      for (int i = 0; i < 32; i++)
        run(OP_PUSH, 1, 0, 8'(i), 1, i);
      chk("q1 full", int'(full[1]), 1);
      chk("q1 count", cnt_of(1), 32);
      run(OP_PUSH, 1, 0, 8'hFF, 1, 31);
      chk("push full err", int'(rsp_err), 1);
      chk("push full count", cnt_of(1), 32);
      for (int i = 0; i < 32; i++) begin
        run(OP_POP, 1, 0, 8'h00, 1, 0);
        chk("drain order", int'(rsp_data), i);
      end
    end

    clear_all();
    run(OP_PUSH, 0, 0, 8'h10, 0, 0);
    run(OP_PUSH, 0, 0, 8'h20, 0, 0);
    run(OP_MOVE, 0, 2, 8'h00, 2, 0);
    chk("move1", int'(rsp_data), 8'h10);
    run(OP_MOVE, 0, 2, 8'h00, 2, 0);
    chk("move2", int'(rsp_data), 8'h20);
    run(OP_MOVE, 0, 2, 8'h00, 2, 1);
    chk("move empty err", int'(rsp_err), 1);
    chk("move empty dst", cnt_of(2), 2);
    for (int i = 0; i < 32; i++)
      run(OP_PUSH, 3, 0, 8'(8'h80 + i), 3, 0);
    run(OP_PUSH, 0, 0, 8'h55, 0, 0);
    run(OP_MOVE, 0, 3, 8'h00, 0, 0);
    chk("move full err", int'(rsp_err), 1);
    chk("move full src", cnt_of(0), 1);

    run(OP_CLEAR, 1, 0, 8'h00, 1, 0);
    for (int i = 0; i < 32; i++)
      run(OP_PUSH, 1, 0, 8'(i), 1, 0);
    run(OP_MOVE, 1, 1, 8'h00, 1, 0);
    chk("rotate data", int'(rsp_data), 0);
    chk("rotate err", int'(rsp_err), 0);
    chk("rotate count", cnt_of(1), 32);
    run(OP_NOP, 0, 0, 8'h00, 1, 31);
    chk("rotate pos31", int'(dmp_data), 0);
    run(OP_NOP, 0, 0, 8'h00, 1, 0);
    chk("rotate pos0", int'(dmp_data), 1);

    run(OP_CLEAR, 2, 0, 8'h00, 2, 0);
    run(OP_PUSH, 2, 0, 8'h0A, 2, 0);
    run(OP_PUSH, 2, 0, 8'h0B, 2, 0);
    run(OP_PUSH, 2, 0, 8'h0C, 2, 0);
    for (int p = 0; p < 4; p++) begin
      run(OP_NOP, 0, 0, 8'h00, 2, p);
      chk("dump valid", int'(dmp_valid), (p < 3) ? 1 : 0);
      chk("dump data", int'(dmp_data), (p < 3) ? 10 + p : 0);
    end
    run(OP_POP, 2, 0, 8'h00, 2, 0);
    chk("dump vs pop", int'(dmp_data), 8'h0A);

    run(OP_CLEAR, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++)
      run(OP_PUSH, 0, 0, 8'(i + 1), 0, 0);
    run(OP_CLEAR, 0, 0, 8'h00, 0, 0);
    chk("clear count", cnt_of(0), 0);
    run(OP_POP, 0, 0, 8'h00, 0, 0);
    chk("pop after clear", int'(rsp_err), 1);
    run(3'd6, 0, 0, 8'h00, 0, 0);
    chk("reserved err", int'(rsp_err), 1);

    cmd_valid = 1'b1;
    cmd_op    = OP_PUSH;
    cmd_q     = 2'd0;
    cmd_data  = 8'h77;
    #2;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      mq[i].delete();
    @(posedge clk);
    #1;
    chk("midreset rsp_valid", int'(rsp_valid), 0);
    chk("midreset count", int'(count), 0);

    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 15));
      if (r < 6)       op_i = OP_PUSH;
      else if (r < 10) op_i = OP_POP;
      else if (r < 13) op_i = OP_MOVE;
      else if (r < 14) op_i = OP_CLEAR;
      else if (r < 15) op_i = OP_NOP;
      else             op_i = int'($urandom_range(5, 7));
      run(3'(op_i), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
